// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// Optional macro SERIAL_ADD_SUB_EN adds the 'sub' request bit.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output start_valid, op_a, op_b, sub, res_ready,
    input  start_ready, res_valid, result, carry_out
  );
  modport slave (
    input  start_valid, op_a, op_b, sub, res_ready,
    output start_ready, res_valid, result, carry_out
  );
`else
  modport master (
    output start_valid, op_a, op_b, res_ready,
    input  start_ready, res_valid, result, carry_out
  );
  modport slave (
    input  start_valid, op_a, op_b, res_ready,
    output start_ready, res_valid, result, carry_out
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder bit sequenced LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_EN enables subtraction (op_a - op_b) selected per operation.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_add_ctrl_if.slave    bus,
  output logic                busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] a_sh_q,      a_sh_d;
  logic [WIDTH-1:0] b_sh_q,      b_sh_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_q,     carry_d;
  logic             carry_out_q, carry_out_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             sub_q,       sub_d;

  logic accept;
  logic b_bit;
  logic ha0_s, ha0_c, sum_bit, ha1_c, cout;
  logic load_sub;

`ifdef SERIAL_ADD_SUB_EN
  assign load_sub = bus.sub;
`else
  assign load_sub = 1'b0;
`endif

  // Subtract is a + ~b + 1: invert the b stream and seed the carry with 1.
  assign b_bit = b_sh_q[0] ^ sub_q;

  half_adder u_ha0 (.a(a_sh_q[0]), .b(b_bit),   .s(ha0_s),   .c(ha0_c));
  half_adder u_ha1 (.a(ha0_s),     .b(carry_q), .s(sum_bit), .c(ha1_c));
  assign cout = ha0_c | ha1_c;

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.res_valid   = (state_q == ST_DONE);
  assign busy            = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.result      = result_q;
  assign bus.carry_out   = carry_out_q;

  assign accept = bus.start_valid && bus.start_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_sh_d  = bus.op_a;
          b_sh_d  = bus.op_b;
          sub_d   = load_sub;
          carry_d = load_sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d = {sum_bit, result_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          carry_out_d = cout;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
      sub_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
    end
  end
endmodule
